ioctl_rom_loader: RTL and testbench

Parametrised download sink between `hps_io` and the core's ROM/RAM ports. It replaces the single-target byte loader with several things:
- up to four address-mapped target regions;
- byte-to-word packing for 8/16/32-bit memories;
- backpressure through `ioctl_wait`;
- an automatic CPU reset hold;
- a running checksum and an overflow error flag for each download.

It sits in `emu` beside `hps_io` and feeds the PC-8001 ROM/PCG/expansion-ROM memories.

---
 rtl/ioctl_rom_loader.sv | 256 +++++++++++++++++++++++++
 tb/tb_ioctl_rom_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_rom_loader.sv
// ioctl_rom_loader: hps_io download sink that maps ioctl bytes onto up to four
// target regions, packs them into DATA_W words and issues them with a req/ack
// handshake, holding the CPU in reset and tracking a checksum and an error flag.
//
// Ports:
//   clk_sys, reset                      clock, synchronous active-high reset
//   ioctl_download/index/wr/addr/dout   byte stream from hps_io
//   ioctl_wait                          stall request back to hps_io
//   mem_req/ack/sel/addr/data/be        word write port (sel is one-hot region)
//   hold_reset                          CPU reset request
//   done                                one-cycle pulse when a download completes
//   error                               sticky: dropped or unmapped byte seen
//   checksum                            sum mod 2^16 of accepted bytes
module ioctl_rom_loader #(
    parameter int                 DATA_W   = 8,
    parameter int                 NREG     = 2,
    parameter int                 ADDR_W   = 16,
    parameter logic [NREG*25-1:0] REG_BASE = {25'h8000, 25'h0},
    parameter logic [NREG*25-1:0] REG_SIZE = {25'h800, 25'h8000},
    parameter logic [7:0]         IDX      = 8'd0,
    parameter int                 HOLD_CYC = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic [7:0]           ioctl_index,
    input  logic                 ioctl_wr,
    input  logic [24:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    output logic                 mem_req,
    input  logic                 mem_ack,
    output logic [NREG-1:0]      mem_sel,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [DATA_W-1:0]    mem_data,
    output logic [DATA_W/8-1:0]  mem_be,
    output logic                 hold_reset,
    output logic                 done,
    output logic                 error,
    output logic [15:0]          checksum
);
    localparam int NB = DATA_W / 8;
    localparam int LW = NB > 1 ? $clog2(NB) : 1;
    localparam int BW = NB + DATA_W;

    typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, FLUSH, HOLD} state_t;

    state_t            state_q, state_d;
    logic              act_q;
    logic [BW-1:0]     wbuf_q, wbuf_d;
    logic [NREG-1:0]   bsel_q, bsel_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic              sk_v_q, sk_v_d;
    logic [NREG-1:0]   sk_sel_q, sk_sel_d;
    logic [ADDR_W-1:0] sk_word_q, sk_word_d;
    logic [LW-1:0]     sk_lane_q, sk_lane_d;
    logic [7:0]        sk_dat_q, sk_dat_d;
    logic              err_q, err_d;
    logic [15:0]       sum_q, sum_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic [15:0]       cnt_q, cnt_d;

    logic              hit;
    logic [NREG-1:0]   sel_n;
    logic [24:0]       off;
    logic [LW-1:0]     lane_n;
    logic [ADDR_W-1:0] word_n;

    // The word buffer keeps byte enables above the data: {be, data}.
    function automatic logic [BW-1:0] put(input logic [BW-1:0] cur, input logic [LW-1:0] lane,
                                          input logic [7:0] dat);
        put = cur;
        for (int b = 0; b < NB; b++)
            if (lane == LW'(b)) begin
                put[DATA_W+b]  = 1'b1;
                put[b*8 +: 8] = dat;
            end
    endfunction

    // Scan from the top region down so the lowest matching region wins.
    always_comb begin
        hit   = 1'b0;
        sel_n = '0;
        off   = '0;
        for (int r = NREG - 1; r >= 0; r--)
            if ({1'b0, ioctl_addr} >= {1'b0, REG_BASE[r*25 +: 25]} &&
                {1'b0, ioctl_addr} <  {1'b0, REG_BASE[r*25 +: 25]} + {1'b0, REG_SIZE[r*25 +: 25]}) begin
                hit      = 1'b1;
                sel_n    = '0;
                sel_n[r] = 1'b1;
                off      = ioctl_addr - REG_BASE[r*25 +: 25];
            end
    end

    assign lane_n = LW'(off % 25'(NB));
    assign word_n = ADDR_W'(off / 25'(NB));

    logic active, rise, fall, wr_v, good, bad, empty, same, top_n;
    logic ld_v, ld_top;
    logic [NREG-1:0]   ld_sel;
    logic [ADDR_W-1:0] ld_word;
    logic [LW-1:0]     ld_lane;
    logic [7:0]        ld_dat;

    assign active = ioctl_download && ioctl_index == IDX;
    assign rise   = active && !act_q;
    assign fall   = act_q && !active;
    // A byte strobed in the same cycle the download drops is still taken.
    assign wr_v   = ioctl_wr && (active || act_q) && (state_q == COLLECT || state_q == ISSUE);
    assign good   = wr_v && hit;
    assign bad    = wr_v && !hit;
    assign empty  = wbuf_q[DATA_W +: NB] == '0;
    assign same   = empty || (sel_n == bsel_q && word_n == baddr_q);
    assign top_n  = lane_n == LW'(NB - 1);

    // On ack the next buffer starts from the skid byte, or else from a byte
    // arriving in that same cycle.
    assign ld_v    = sk_v_q || good;
    assign ld_sel  = sk_v_q ? sk_sel_q : sel_n;
    assign ld_word = sk_v_q ? sk_word_q : word_n;
    assign ld_lane = sk_v_q ? sk_lane_q : lane_n;
    assign ld_dat  = sk_v_q ? sk_dat_q : ioctl_dout;
    assign ld_top  = ld_lane == LW'(NB - 1);

    // Request and stall are gated by reset so an abort drops them at once.
    assign mem_req    = !reset && (state_q == ISSUE || (state_q == FLUSH && !empty));
    assign ioctl_wait = !reset && (state_q == ISSUE || state_q == FLUSH || sk_v_q);

    always_comb begin
        state_d   = state_q;
        wbuf_d    = wbuf_q;
        bsel_d    = bsel_q;
        baddr_d   = baddr_q;
        sk_v_d    = sk_v_q;
        sk_sel_d  = sk_sel_q;
        sk_word_d = sk_word_q;
        sk_lane_d = sk_lane_q;
        sk_dat_d  = sk_dat_q;
        err_d     = err_q || bad || (good && sk_v_q);
        sum_d     = sum_q;
        hold_d    = hold_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE, HOLD: begin
                if (rise) begin
                    state_d = COLLECT;
                    err_d   = 1'b0;
                    sum_d   = '0;
                    wbuf_d  = '0;
                    sk_v_d  = 1'b0;
                    hold_d  = 1'b1;
                end else if (state_q == HOLD) begin
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == 16'(HOLD_CYC - 1)) begin
                        state_d = IDLE;
                        hold_d  = 1'b0;
                    end
                end
            end
            COLLECT: begin
                if (good && same) begin
                    wbuf_d  = put(wbuf_q, lane_n, ioctl_dout);
                    bsel_d  = sel_n;
                    baddr_d = word_n;
                    sum_d   = sum_q + {8'd0, ioctl_dout};
                    state_d = top_n ? ISSUE : fall ? FLUSH : COLLECT;
                end else if (good) begin
                    sk_v_d    = 1'b1;
                    sk_sel_d  = sel_n;
                    sk_word_d = word_n;
                    sk_lane_d = lane_n;
                    sk_dat_d  = ioctl_dout;
                    sum_d     = sum_q + {8'd0, ioctl_dout};
                    state_d   = ISSUE;
                end else if (fall) begin
                    state_d = FLUSH;
                end
            end
            ISSUE: begin
                if (good && !sk_v_q)
                    sum_d = sum_q + {8'd0, ioctl_dout};
                if (mem_ack) begin
                    sk_v_d  = 1'b0;
                    wbuf_d  = ld_v ? put('0, ld_lane, ld_dat) : '0;
                    bsel_d  = ld_v ? ld_sel : bsel_q;
                    baddr_d = ld_v ? ld_word : baddr_q;
                    state_d = ld_v && ld_top ? ISSUE : active ? COLLECT : ld_v ? FLUSH : HOLD;
                    done_d  = !ld_v && !active;
                    cnt_d   = '0;
                end else if (good && !sk_v_q) begin
                    sk_v_d    = 1'b1;
                    sk_sel_d  = sel_n;
                    sk_word_d = word_n;
                    sk_lane_d = lane_n;
                    sk_dat_d  = ioctl_dout;
                end
            end
            FLUSH: begin
                if (empty || mem_ack) begin
                    state_d = HOLD;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    wbuf_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= IDLE;
            act_q     <= 1'b0;
            wbuf_q    <= '0;
            bsel_q    <= '0;
            baddr_q   <= '0;
            sk_v_q    <= 1'b0;
            sk_sel_q  <= '0;
            sk_word_q <= '0;
            sk_lane_q <= '0;
            sk_dat_q  <= '0;
            err_q     <= 1'b0;
            sum_q     <= '0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            act_q     <= active;
            wbuf_q    <= wbuf_d;
            bsel_q    <= bsel_d;
            baddr_q   <= baddr_d;
            sk_v_q    <= sk_v_d;
            sk_sel_q  <= sk_sel_d;
            sk_word_q <= sk_word_d;
            sk_lane_q <= sk_lane_d;
            sk_dat_q  <= sk_dat_d;
            err_q     <= err_d;
            sum_q     <= sum_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign mem_sel    = bsel_q;
    assign mem_addr   = baddr_q;
    assign mem_data   = wbuf_q[DATA_W-1:0];
    assign mem_be     = wbuf_q[DATA_W +: NB];
    assign hold_reset = hold_q;
    assign done       = done_q;
    assign error      = err_q;
    assign checksum   = sum_q;
endmodule

// File: tb/tb_ioctl_rom_loader.sv
// tb_ioctl_rom_loader: scoreboard bench for ioctl_rom_loader with 16-bit words.
module tb_ioctl_rom_loader;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        mem_req;
    logic        mem_ack = 1'b0;
    logic [1:0]  mem_sel;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic [1:0]  mem_be;
    logic        hold_reset;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    always #5 clk = ~clk;

    ioctl_rom_loader #(
        .DATA_W(16), .NREG(2), .ADDR_W(16),
        .REG_BASE({25'h8000, 25'h0}), .REG_SIZE({25'h800, 25'h8000}),
        .IDX(8'd0), .HOLD_CYC(H)
    ) dut (
        .clk_sys(clk), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
        .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_req(mem_req),
        .mem_ack(mem_ack), .mem_sel(mem_sel), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_be(mem_be), .hold_reset(hold_reset),
        .done(done), .error(error), .checksum(checksum)
    );

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0, fails = 0;
    int  cyc = 0, ack_lat = 0, req_cnt = 0, req_seen = 0;
    int  last_ack = -1, hold_fall = -1, done_cyc = -1, done_cnt = 0;
    logic hold_prev = 1'b0;
    wr_t  cap;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Target model and monitor: acks after ack_lat extra cycles and checks
    // each acked word against the scoreboard.
    initial forever begin
        wr_t cur, e;
        @(negedge clk);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (hold_prev && !hold_reset) hold_fall = cyc;
        hold_prev = hold_reset;
        if (mem_req) begin
            cur = {mem_sel, mem_addr, mem_data, mem_be};
            chk("wait_during_req", {63'd0, ioctl_wait}, 64'd1);
            if (req_cnt == 0) begin
                cap = cur;
                req_seen++;
            end else begin
                chk("req_stable", cur, cap);
            end
            if (req_cnt == ack_lat) begin
                mem_ack  = 1'b1;
                last_ack = cyc;
                req_cnt  = 0;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write actual=%0h required=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("write", cur, e);
                end
            end else begin
                mem_ack = 1'b0;
                req_cnt++;
            end
        end else begin
            mem_ack = 1'b0;
            req_cnt = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d);
        int n = 0;
        while (ioctl_wait && n < 50) begin
            tick();
            n++;
        end
        chk("wait_release", {63'd0, n < 50}, 64'd1);
        pulse(a, d);
    endtask

    task automatic start(input logic [7:0] idx);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        tick();
    endtask

    task automatic wait_end(input string nm, input bit timed, input int d0);
        int n = 0;
        while (hold_reset && n < 300) begin
            tick();
            n++;
        end
        chk($sformatf("%s_hold_timeout", nm), {63'd0, n < 300}, 64'd1);
        @(negedge clk);
        #1;
        if (timed) begin
            chk($sformatf("%s_hold_fall", nm), 64'(hold_fall - last_ack), 64'(H + 1));
            chk($sformatf("%s_done_lat", nm), 64'(done_cyc - last_ack), 64'd1);
        end
        chk($sformatf("%s_done_cnt", nm), 64'(done_cnt - d0), 64'd1);
        chk($sformatf("%s_queue", nm), 64'(exp_q.size()), 64'd0);
        tick();
        tick();
    endtask

    initial begin
        int d0, rs;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        repeat (3) tick();
        chk("rst_req", {63'd0, mem_req}, 64'd0);
        chk("rst_hold", {63'd0, hold_reset}, 64'd0);
        chk("rst_wait", {63'd0, ioctl_wait}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_error", {63'd0, error}, 64'd0);
        chk("rst_sum", {48'd0, checksum}, 64'd0);
        chk("rst_be", {62'd0, mem_be}, 64'd0);
        reset = 1'b0;
        tick();

        // 8 bytes, zero-wait target
        ack_lat = 0;
        d0 = done_cnt;
        start(8'd0);
        chk("t1_hold_rise", {63'd0, hold_reset}, 64'd1);
        for (int i = 0; i < 4; i++)
            exp_q.push_back({2'b01, 16'(i), 8'(2 * i + 1), 8'(2 * i), 2'b11});
        for (int i = 0; i < 8; i++) pulse(25'(i), 8'(i));
        ioctl_download = 1'b0;
        wait_end("t1", 1'b1, d0);
        chk("t1_sum", {48'd0, checksum}, 64'h1C);
        chk("t1_err", {63'd0, error}, 64'd0);

        // odd length: partial final word
        d0 = done_cnt;
        start(8'd0);
        exp_q.push_back({2'b01, 16'h0000, 16'hA1A0, 2'b11});
        exp_q.push_back({2'b01, 16'h0001, 16'h00A2, 2'b01});
        pulse(25'd0, 8'hA0);
        pulse(25'd1, 8'hA1);
        pulse(25'd2, 8'hA2);
        ioctl_download = 1'b0;
        wait_end("t2", 1'b1, d0);
        chk("t2_sum", {48'd0, checksum}, 64'h1E3);
        chk("t2_err", {63'd0, error}, 64'd0);

        // region crossing and word conflict through the skid
        ack_lat = 1;
        d0 = done_cnt;
        start(8'd0);
        exp_q.push_back({2'b01, 16'h3FFF, 16'h1100, 2'b10});
        exp_q.push_back({2'b10, 16'h0000, 16'h0022, 2'b01});
        exp_q.push_back({2'b10, 16'h0002, 16'h0044, 2'b01});
        pulse(25'h7FFF, 8'h11);
        pulse(25'h8000, 8'h22);
        send(25'h8004, 8'h44);
        ioctl_download = 1'b0;
        wait_end("t3", 1'b1, d0);
        chk("t3_sum", {48'd0, checksum}, 64'h77);
        chk("t3_err", {63'd0, error}, 64'd0);

        // unmapped byte
        ack_lat = 0;
        d0 = done_cnt;
        rs = req_seen;
        start(8'd0);
        send(25'h9000, 8'h55);
        ioctl_download = 1'b0;
        wait_end("t4", 1'b0, d0);
        chk("t4_err", {63'd0, error}, 64'd1);
        chk("t4_sum", {48'd0, checksum}, 64'd0);
        chk("t4_noreq", 64'(req_seen - rs), 64'd0);

        // slow target, skid full, extra byte dropped
        ack_lat = 4;
        d0 = done_cnt;
        start(8'd0);
        exp_q.push_back({2'b01, 16'h0000, 16'h0201, 2'b11});
        exp_q.push_back({2'b01, 16'h0001, 16'h0003, 2'b01});
        pulse(25'd0, 8'h01);
        pulse(25'd1, 8'h02);
        pulse(25'd2, 8'h03);
        pulse(25'd3, 8'h04);
        chk("t5_err", {63'd0, error}, 64'd1);
        send(25'h9000, 8'h00);
        ioctl_download = 1'b0;
        wait_end("t5", 1'b1, d0);
        chk("t5_sum", {48'd0, checksum}, 64'd6);

        // reset in the middle of an issue
        start(8'd0);
        pulse(25'd0, 8'h11);
        pulse(25'd1, 8'h22);
        chk("t6_req_pre", {63'd0, mem_req}, 64'd1);
        reset = 1'b1;
        tick();
        chk("t6_req", {63'd0, mem_req}, 64'd0);
        chk("t6_hold", {63'd0, hold_reset}, 64'd0);
        chk("t6_wait", {63'd0, ioctl_wait}, 64'd0);
        ioctl_download = 1'b0;
        reset = 1'b0;
        tick();
        rs = req_seen;
        d0 = done_cnt;
        start(8'd1);
        pulse(25'd0, 8'hAA);
        pulse(25'd1, 8'hBB);
        ioctl_download = 1'b0;
        repeat (10) tick();
        chk("t7_hold", {63'd0, hold_reset}, 64'd0);
        chk("t7_noreq", 64'(req_seen - rs), 64'd0);
        chk("t7_nodone", 64'(done_cnt - d0), 64'd0);
        chk("t7_sum", {48'd0, checksum}, 64'd0);
        chk("t7_err", {63'd0, error}, 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
